// File: rtl/sl_rxbuf_pingpong_pkg.sv
// Shared constants, write-FSM state encoding and small helpers for the
// s_link ping-pong receive buffer.
package sl_rxbuf_pingpong_pkg;

  localparam int unsigned SL_BUF_DEPTH = 2048;
  localparam int unsigned SL_ADDR_W    = 11;
  localparam int unsigned SL_LEN_W     = 12;
  localparam int unsigned SL_DATA_W    = 8;
  localparam int unsigned SL_OVF_W     = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } sl_wr_state_e;

  function automatic logic [SL_OVF_W-1:0] sl_sat_inc(input logic [SL_OVF_W-1:0] v);
    return (v == '1) ? v : v + SL_OVF_W'(1);
  endfunction

endpackage

// File: rtl/sl_dpram_2k8.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Contents are not reset; the read register holds while re_i is low.
module sl_dpram_2k8
  import sl_rxbuf_pingpong_pkg::*;
#(
  parameter int unsigned DEPTH = SL_BUF_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [SL_ADDR_W-1:0] waddr_i,
  input  logic [SL_DATA_W-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [SL_ADDR_W-1:0] raddr_i,
  output logic [SL_DATA_W-1:0] rdata_o
);

  logic [SL_DATA_W-1:0] mem_q [DEPTH];
  logic [SL_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sl_rxbuf_pingpong.sv
// Two-bank receive frame buffer: s_link bytes fill one bank while the
// consumer reads the other; a frame closes after IDLE_GAP write-idle cycles.
module sl_rxbuf_pingpong
  import sl_rxbuf_pingpong_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 16,
  parameter int unsigned DEPTH    = SL_BUF_DEPTH
) (
  input  logic                 sys_clk,
  input  logic                 glb_rst_n,
  input  logic                 i_sl_wren,
  input  logic [SL_ADDR_W-1:0] i_sl_waddr,
  input  logic [SL_DATA_W-1:0] i_sl_wdata,
  output logic                 o_frm_rdy,
  output logic [SL_LEN_W-1:0]  o_frm_len,
  input  logic                 i_rd_en,
  input  logic [SL_ADDR_W-1:0] i_rd_addr,
  output logic [SL_DATA_W-1:0] o_rd_data,
  input  logic                 i_frm_ack,
  output logic [SL_OVF_W-1:0]  o_ovf_cnt
);

  localparam int unsigned CNT_W = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP);

  sl_wr_state_e               state_q, state_d;
  logic [CNT_W-1:0]           idle_cnt_q, idle_cnt_d;
  logic [SL_ADDR_W-1:0]       max_addr_q, max_addr_d;
  logic [1:0]                 full_q, full_d;
  logic [1:0][SL_LEN_W-1:0]   len_q, len_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic                       ack_gap_q, ack_gap_d;
  logic [SL_OVF_W-1:0]        ovf_q, ovf_d;
  logic                       rd_sel_q;
  logic                       rd_vld_q;

  logic                       store;
  logic                       gap_hit;
  logic                       ack_take;
  logic                       frm_rdy;
  logic [1:0]                 bank_we;
  logic [1:0][SL_DATA_W-1:0]  bank_rdata;

  // ack_gap_q forces o_frm_rdy low for the cycle after an accepted ack,
  // even when the other bank already holds the next frame.
  assign frm_rdy  = full_q[rd_ptr_q] & ~ack_gap_q;
  assign ack_take = i_frm_ack & frm_rdy;
  assign gap_hit  = (idle_cnt_q == CNT_W'(IDLE_GAP - 1));

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    max_addr_d = max_addr_q;
    full_d     = full_q;
    len_d      = len_q;
    wr_bank_d  = wr_bank_q;
    rd_ptr_d   = rd_ptr_q;
    ack_gap_d  = 1'b0;
    ovf_d      = ovf_q;
    store      = 1'b0;

    case (state_q)
      W_IDLE: begin
        if (i_sl_wren) begin
          idle_cnt_d = '0;
          if (!full_q[wr_bank_q]) begin
            store      = 1'b1;
            max_addr_d = i_sl_waddr;
            state_d    = W_RECV;
          end else begin
            state_d    = W_DROP;
          end
        end
      end
      W_RECV: begin
        if (i_sl_wren) begin
          store      = 1'b1;
          idle_cnt_d = '0;
          if (i_sl_waddr > max_addr_q) begin
            max_addr_d = i_sl_waddr;
          end
        end else if (gap_hit) begin
          full_d[wr_bank_q] = 1'b1;
          len_d[wr_bank_q]  = {1'b0, max_addr_q} + SL_LEN_W'(1);
          wr_bank_d         = ~wr_bank_q;
          idle_cnt_d        = '0;
          max_addr_d        = '0;
          state_d           = W_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      W_DROP: begin
        if (i_sl_wren) begin
          idle_cnt_d = '0;
        end else if (gap_hit) begin
          ovf_d      = sl_sat_inc(ovf_q);
          idle_cnt_d = '0;
          state_d    = W_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase

    // A closing bank is always FREE and the acked bank always FULL, so the
    // two updates never touch the same bank.
    if (ack_take) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
      ack_gap_d        = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge glb_rst_n) begin
    if (!glb_rst_n) begin
      state_q    <= W_IDLE;
      idle_cnt_q <= '0;
      max_addr_q <= '0;
      full_q     <= '0;
      len_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ack_gap_q  <= 1'b0;
      ovf_q      <= '0;
      rd_sel_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      max_addr_q <= max_addr_d;
      full_q     <= full_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      ack_gap_q  <= ack_gap_d;
      ovf_q      <= ovf_d;
      if (i_rd_en) begin
        rd_sel_q <= rd_ptr_q;
        rd_vld_q <= 1'b1;
      end
    end
  end

  assign bank_we[0] = store & ~wr_bank_q;
  assign bank_we[1] = store &  wr_bank_q;

  sl_dpram_2k8 #(
    .DEPTH (DEPTH)
  ) u_bank0 (
    .clk_i   (sys_clk),
    .we_i    (bank_we[0]),
    .waddr_i (i_sl_waddr),
    .wdata_i (i_sl_wdata),
    .re_i    (i_rd_en),
    .raddr_i (i_rd_addr),
    .rdata_o (bank_rdata[0])
  );

  sl_dpram_2k8 #(
    .DEPTH (DEPTH)
  ) u_bank1 (
    .clk_i   (sys_clk),
    .we_i    (bank_we[1]),
    .waddr_i (i_sl_waddr),
    .wdata_i (i_sl_wdata),
    .re_i    (i_rd_en),
    .raddr_i (i_rd_addr),
    .rdata_o (bank_rdata[1])
  );

  // RAM read registers are not reset; rd_vld_q keeps o_rd_data at zero
  // until the first read after reset.
  assign o_rd_data = rd_vld_q ? bank_rdata[rd_sel_q] : '0;
  assign o_frm_rdy = frm_rdy;
  assign o_frm_len = frm_rdy ? len_q[rd_ptr_q] : '0;
  assign o_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_sl_rxbuf_pingpong.sv
// Randomised and directed bench for sl_rxbuf_pingpong against a
// frame-level reference model (queue of held frames, drop counter).
module tb_sl_rxbuf_pingpong;

  localparam int unsigned GAP = 16;

  logic        sys_clk;
  logic        glb_rst_n;
  logic        i_sl_wren;
  logic [10:0] i_sl_waddr;
  logic [7:0]  i_sl_wdata;
  logic        o_frm_rdy;
  logic [11:0] o_frm_len;
  logic        i_rd_en;
  logic [10:0] i_rd_addr;
  logic [7:0]  o_rd_data;
  logic        i_frm_ack;
  logic [7:0]  o_ovf_cnt;

  int unsigned n_chk;
  int unsigned n_err;
  int unsigned mq[$];
  int unsigned wq[$];
  int unsigned flen[256];
  int unsigned m_ovf;
  int unsigned nxt_fid;
  int unsigned fid;

  sl_rxbuf_pingpong #(
    .IDLE_GAP (GAP),
    .DEPTH    (2048)
  ) dut (
    .sys_clk    (sys_clk),
    .glb_rst_n  (glb_rst_n),
    .i_sl_wren  (i_sl_wren),
    .i_sl_waddr (i_sl_waddr),
    .i_sl_wdata (i_sl_wdata),
    .o_frm_rdy  (o_frm_rdy),
    .o_frm_len  (o_frm_len),
    .i_rd_en    (i_rd_en),
    .i_rd_addr  (i_rd_addr),
    .o_rd_data  (o_rd_data),
    .i_frm_ack  (i_frm_ack),
    .o_ovf_cnt  (o_ovf_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int unsigned f, input int unsigned a);
    return 8'((f * 29) ^ (a * 7) ^ (a >> 8) ^ 8'h5A);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic build_seq(input int unsigned len, input bit shuf);
    int unsigned j;
    int unsigned t;
    wq.delete();
    for (int unsigned i = 0; i < len; i++) wq.push_back(i);
    if (shuf) begin
      for (int unsigned i = len - 1; i > 0; i--) begin
        j     = $urandom_range(i, 0);
        t     = wq[i];
        wq[i] = wq[j];
        wq[j] = t;
      end
    end
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_rdy"}, 32'(o_frm_rdy), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_len"}, 32'(o_frm_len), flen[mq[0]]);
  endtask

  // Sends the address list in wq as one frame, then idles until it closes.
  task automatic send_frame(input bit ack_at_close, input int unsigned max_gap,
                            output int unsigned f);
    int unsigned mx;
    bit          acc;
    f   = nxt_fid;
    nxt_fid++;
    mx  = 0;
    acc = (mq.size() < 2);
    for (int unsigned k = 0; k < wq.size(); k++) begin
      if (wq[k] > mx) mx = wq[k];
      i_sl_wren  = 1'b1;
      i_sl_waddr = 11'(wq[k]);
      i_sl_wdata = byte_of(f, wq[k]);
      tick();
      i_sl_wren  = 1'b0;
      if (k + 1 < wq.size()) repeat ($urandom_range(max_gap, 0)) tick();
    end
    repeat (GAP - 1) tick();
    check_head("pre_close");
    chk("pre_close_ovf", 32'(o_ovf_cnt), m_ovf);
    if (ack_at_close) i_frm_ack = 1'b1;
    tick();
    i_frm_ack = 1'b0;
    if (ack_at_close && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      flen[f] = mx + 1;
      mq.push_back(f);
    end else if (m_ovf < 255) begin
      m_ovf++;
    end
  endtask

  task automatic read_chk(input string tag, input int unsigned a);
    logic [7:0] exp;
    exp       = byte_of(mq[0], a);
    i_rd_en   = 1'b1;
    i_rd_addr = 11'(a);
    tick();
    i_rd_en   = 1'b0;
    i_rd_addr = 11'($urandom_range(2047, 0));
    chk({tag, "_data"}, 32'(o_rd_data), 32'(exp));
    tick();
    chk({tag, "_hold"}, 32'(o_rd_data), 32'(exp));
  endtask

  task automatic do_ack(input bit stray);
    i_frm_ack = 1'b1;
    tick();
    i_frm_ack = 1'b0;
    void'(mq.pop_front());
    chk("ack_gap_rdy", 32'(o_frm_rdy), 32'(0));
    if (stray) i_frm_ack = 1'b1;
    tick();
    i_frm_ack = 1'b0;
    check_head("post_ack");
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 2 && mq.size() > 0; n++) do_ack(1'b0);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    m_ovf      = 0;
    nxt_fid    = 1;
    glb_rst_n  = 1'b0;
    i_sl_wren  = 1'b0;
    i_sl_waddr = '0;
    i_sl_wdata = '0;
    i_rd_en    = 1'b0;
    i_rd_addr  = '0;
    i_frm_ack  = 1'b0;
    repeat (3) tick();
    chk("rst_rdy",  32'(o_frm_rdy), 32'(0));
    chk("rst_len",  32'(o_frm_len), 32'(0));
    chk("rst_data", 32'(o_rd_data), 32'(0));
    chk("rst_ovf",  32'(o_ovf_cnt), 32'(0));
    glb_rst_n = 1'b1;
    tick();

    // 64-byte frame, read byte 5
    build_seq(64, 1'b0);
    send_frame(1'b0, 0, fid);
    check_head("f64");
    chk("f64_len_abs", 32'(o_frm_len), 32'(64));
    read_chk("f64_a5", 5);
    do_ack(1'b1);

    // 10 then 20 bytes back to back
    build_seq(10, 1'b0);
    send_frame(1'b0, 0, fid);
    build_seq(20, 1'b1);
    send_frame(1'b0, 2, fid);
    chk("f10_len", 32'(o_frm_len), 32'(10));
    read_chk("f10_a9", 9);
    do_ack(1'b0);
    chk("f20_len", 32'(o_frm_len), 32'(20));
    read_chk("f20_a19", 19);
    drain();

    // ack coincides with second frame's close
    build_seq(12, 1'b0);
    send_frame(1'b0, 0, fid);
    build_seq(30, 1'b1);
    send_frame(1'b1, 1, fid);
    chk("coinc_gap_rdy", 32'(o_frm_rdy), 32'(0));
    tick();
    check_head("coinc");
    chk("coinc_len_abs", 32'(o_frm_len), 32'(30));
    build_seq(5, 1'b0);
    send_frame(1'b0, 0, fid);
    chk("coinc_ovf", 32'(o_ovf_cnt), 32'(0));
    read_chk("coinc_a29", 29);
    do_ack(1'b0);
    read_chk("coinc_next_a4", 4);
    drain();

    // ack with nothing ready is ignored
    i_frm_ack = 1'b1;
    tick();
    i_frm_ack = 1'b0;
    check_head("idle_ack");

    // third frame dropped
    build_seq(12, 1'b0);
    send_frame(1'b0, 0, fid);
    build_seq(7, 1'b1);
    send_frame(1'b0, 3, fid);
    build_seq(9, 1'b0);
    send_frame(1'b0, 0, fid);
    chk("drop_ovf", 32'(o_ovf_cnt), 32'(1));
    check_head("drop_f1");
    read_chk("drop_f1_a0", 0);
    read_chk("drop_f1_a11", 11);
    do_ack(1'b0);
    chk("drop_f2_len", 32'(o_frm_len), 32'(7));
    read_chk("drop_f2_a6", 6);
    drain();

    // out-of-order sparse writes
    wq = '{100, 3};
    send_frame(1'b0, 2, fid);
    chk("ooo_len", 32'(o_frm_len), 32'(101));
    read_chk("ooo_a100", 100);
    read_chk("ooo_a3", 3);
    drain();

    // maximum length frame
    wq = '{2047, 0};
    send_frame(1'b0, 0, fid);
    chk("max_len", 32'(o_frm_len), 32'(2048));
    read_chk("max_a2047", 2047);
    drain();

    // randomised frames, reads and acks
    for (int unsigned it = 0; it < 30; it++) begin
      build_seq($urandom_range(48, 1), 1'($urandom_range(1, 0)));
      send_frame(1'b0, 3, fid);
      chk("rnd_ovf", 32'(o_ovf_cnt), m_ovf);
      check_head("rnd");
      if (mq.size() > 0 && $urandom_range(2, 0) != 0)
        read_chk("rnd", $urandom_range(flen[mq[0]] - 1, 0));
      if (mq.size() > 0 && $urandom_range(1, 0) == 1)
        do_ack(1'($urandom_range(1, 0)));
    end

    // reset in the middle of a frame
    i_sl_wren = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      i_sl_waddr = 11'(i);
      i_sl_wdata = 8'hA5;
      tick();
    end
    #2;
    glb_rst_n = 1'b0;
    #1;
    i_sl_wren = 1'b0;
    chk("mid_rst_rdy",  32'(o_frm_rdy), 32'(0));
    chk("mid_rst_len",  32'(o_frm_len), 32'(0));
    chk("mid_rst_data", 32'(o_rd_data), 32'(0));
    chk("mid_rst_ovf",  32'(o_ovf_cnt), 32'(0));
    mq.delete();
    m_ovf = 0;
    tick();
    glb_rst_n = 1'b1;
    tick();
    build_seq(8, 1'b1);
    send_frame(1'b0, 2, fid);
    check_head("post_rst");
    chk("post_rst_len", 32'(o_frm_len), 32'(8));
    chk("post_rst_ovf", 32'(o_ovf_cnt), 32'(0));
    read_chk("post_rst_a7", 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
